// File: rtl/clk_div_bank_pkg.sv
// Shared constants and helpers for the clock-divider bank.
package clk_div_bank_pkg;

  // Smallest divisor a channel can run at; programmed 0 and 1 are raised to this.
  localparam int unsigned MIN_DIV = 2;

  // Width of a channel-select field for n channels (never narrower than 1 bit).
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Raise illegal divisors (0, 1) to MIN_DIV; legal values pass unchanged.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One integer divider channel: counter, active/pending divisor, registered waveform + tick.
// Ports:
//   clk, reset          clock, async active-high reset
//   en                  run enable; low forces counter/outputs to zero
//   load, load_div      accept a new divisor (ignored while one is already pending)
//   clk_out, tick       registered divided waveform and 1-cycle rise strobe
//   clk_out_c           next-state of clk_out, for the bank's registered AND
//   cfg_ready           high when no divisor update is pending
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             clk_out,
  output logic             tick,
  output logic             clk_out_c,
  output logic             cfg_ready
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend_div;
  logic             pending;

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] clamped;
  logic             wrap;
  logic             apply;
  logic             accept;

  // Next counter value, wrap detection and waveform next-state.
  always_comb begin
    half      = (div >> 1) + CNT_W'(div[0]);
    wrap      = (cnt == (div - CNT_W'(1)));
    // A pending divisor lands at the period boundary, or at once when idle.
    apply     = pending & (~en | wrap);
    accept    = load & ~pending;
    cnt_nxt   = (en & ~wrap) ? (cnt + CNT_W'(1)) : '0;
    clk_out_c = en & (cnt_nxt < half);
    clamped   = CNT_W'(clamp_div(32'(load_div)));
    cfg_ready = ~pending;
  end

  // Channel state; an accept on a wrap edge only sets pending, so it waits a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div      <= CNT_W'(DEFAULT_DIV);
      pend_div <= CNT_W'(DEFAULT_DIV);
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= clk_out_c;
      tick    <= en & wrap;
      if (apply) begin
        div     <= pend_div;
        pending <= 1'b0;
      end else if (accept) begin
        pend_div <= clamped;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent integer clock dividers with a shared divisor-update port
// and a registered masked AND of the divided waveforms.
// Ports:
//   clk, reset                  clock, async active-high reset
//   en[NUM_CH]                  per-channel run enable
//   cfg_valid/cfg_ready         divisor update handshake (cfg_ready combinational on cfg_ch)
//   cfg_ch, cfg_div             target channel and new divisor
//   and_mask[NUM_CH]            channels contributing to Y
//   clk_out[NUM_CH], tick       registered waveforms and rise strobes
//   Y                           registered AND of masked clk_out, 0 when mask is empty
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 4,
  parameter int unsigned  CNT_W       = 16,
  parameter int unsigned  DEFAULT_DIV = 2,
  localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] and_mask,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              Y
);

  logic [NUM_CH-1:0] chan_ready;
  logic [NUM_CH-1:0] chan_load;
  logic [NUM_CH-1:0] clk_out_c;
  logic              y_nxt;

  // Channel decode; out-of-range cfg_ch matches nothing and reports ready.
  always_comb begin
    cfg_ready = 1'b1;
    chan_load = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready    = chan_ready[i];
        chan_load[i] = cfg_valid & chan_ready[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .en        (en[g]),
      .load      (chan_load[g]),
      .load_div  (cfg_div),
      .clk_out   (clk_out[g]),
      .tick      (tick[g]),
      .clk_out_c (clk_out_c[g]),
      .cfg_ready (chan_ready[g])
    );
  end

  // Built from clk_out next-state so Y lines up with clk_out on the same edge.
  always_comb begin
    y_nxt = (|and_mask) & (&(clk_out_c | ~and_mask));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y <= 1'b0;
    end else begin
      Y <= y_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (NUM_CH=4, CNT_W=16, DEFAULT_DIV=2).
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  and_mask;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic        y;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(
    .NUM_CH      (4),
    .CNT_W       (16),
    .DEFAULT_DIV (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .and_mask  (and_mask),
    .clk_out   (clk_out),
    .tick      (tick),
    .Y         (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program a (disabled) channel: accept on one edge, applied on the next.
  task automatic prog_disabled(input logic [1:0] ch, input logic [15:0] div);
    en[ch]    = 1'b0;
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_valid = 1'b1;
    #1;
    chk("pd_rdy_pre", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("pd_rdy_busy", 32'(cfg_ready), 32'h0);
    chk("pd_clk_off", 32'(clk_out[ch]), 32'h0);
    step();
    chk("pd_rdy_done", 32'(cfg_ready), 32'h1);
  endtask

  logic [5:0] b_clk;
  logic [5:0] b_tick;

  initial begin
    b_clk     = 6'b100111;
    b_tick    = 6'b100001;
    reset     = 1'b1;
    en        = 4'hF;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd0;
    and_mask  = 4'h0;

    // 1: reset state and default period 2 on every channel
    #12;
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_rdy", 32'(cfg_ready), 32'h1);
    reset = 1'b0;
    step();
    chk("t1_e1_clk", 32'(clk_out), 32'h0);
    chk("t1_e1_tick", 32'(tick), 32'h0);
    step();
    chk("t1_e2_clk", 32'(clk_out), 32'hF);
    chk("t1_e2_tick", 32'(tick), 32'hF);
    chk("t1_e2_y", 32'(y), 32'h0);
    step();
    chk("t1_e3_clk", 32'(clk_out), 32'h0);
    step();
    chk("t1_e4_clk", 32'(clk_out), 32'hF);

    // 2: ch1 gets N=5 mid-period; applied at the next wrap
    cfg_ch    = 2'd1;
    cfg_div   = 16'd5;
    cfg_valid = 1'b1;
    #1;
    chk("t2_rdy_pre", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t2_rdy_busy", 32'(cfg_ready), 32'h0);
    chk("t2_clk_old", 32'(clk_out[1]), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_clk", 32'(clk_out[1]), 32'(b_clk[k]));
      chk("t2_tick", 32'(tick[1]), 32'(b_tick[k]));
      if (k == 0) chk("t2_rdy_done", 32'(cfg_ready), 32'h1);
    end

    // 3: divisors 0 and 1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      prog_disabled(2'd1, 16'(d));
      en[1] = 1'b1;
      step();
      chk("t3_e1_clk", 32'(clk_out[1]), 32'h0);
      step();
      chk("t3_e2_clk", 32'(clk_out[1]), 32'h1);
      chk("t3_e2_tick", 32'(tick[1]), 32'h1);
      step();
      chk("t3_e3_clk", 32'(clk_out[1]), 32'h0);
      chk("t3_e3_tick", 32'(tick[1]), 32'h0);
      step();
      chk("t3_e4_tick", 32'(tick[1]), 32'h1);
    end

    // 3b: maximum divisor 65535, H=32768
    prog_disabled(2'd1, 16'hFFFF);
    en[1] = 1'b1;
    repeat (32766) step();
    step();
    chk("t3m_e32767_clk", 32'(clk_out[1]), 32'h1);
    step();
    chk("t3m_e32768_clk", 32'(clk_out[1]), 32'h0);
    repeat (32765) step();
    step();
    chk("t3m_e65534_clk", 32'(clk_out[1]), 32'h0);
    chk("t3m_e65534_tick", 32'(tick[1]), 32'h0);
    step();
    chk("t3m_e65535_clk", 32'(clk_out[1]), 32'h1);
    chk("t3m_e65535_tick", 32'(tick[1]), 32'h1);
    step();
    chk("t3m_e65536_clk", 32'(clk_out[1]), 32'h1);
    chk("t3m_e65536_tick", 32'(tick[1]), 32'h0);
    en[1] = 1'b0;

    // 4: ch0 N=2 and ch2 N=8 in phase, mask 0101
    en[0] = 1'b0;
    prog_disabled(2'd2, 16'd8);
    en[0]    = 1'b1;
    en[2]    = 1'b1;
    and_mask = 4'b0101;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t4_y", 32'(y), 32'(((k % 2) == 0) && ((k % 8) < 4)));
      chk("t4_clk2", 32'(clk_out[2]), 32'((k % 8) < 4));
    end
    and_mask = 4'h0;

    // 5: back-to-back writes to ch3 stall; ch0 stays writable
    en[3] = 1'b0;
    step();
    en[3]     = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 16'd4;
    cfg_valid = 1'b1;
    #1;
    chk("t5_rdy_first", 32'(cfg_ready), 32'h1);
    step();
    cfg_div = 16'd6;
    #1;
    chk("t5_rdy_stall", 32'(cfg_ready), 32'h0);
    step();
    chk("t5_rdy_free", 32'(cfg_ready), 32'h1);
    chk("t5_wrap_tick", 32'(tick[3]), 32'h1);
    chk("t5_wrap_clk", 32'(clk_out[3]), 32'h1);
    step();
    chk("t5_n4_clk", 32'(clk_out[3]), 32'h1);
    cfg_ch  = 2'd0;
    cfg_div = 16'd2;
    #1;
    chk("t5_ch0_rdy", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t5_ch0_busy", 32'(cfg_ready), 32'h0);
    cfg_ch = 2'd3;
    #1;
    chk("t5_ch3_busy", 32'(cfg_ready), 32'h0);
    chk("t5_n4_low", 32'(clk_out[3]), 32'h0);
    step();
    chk("t5_ch3_busy2", 32'(cfg_ready), 32'h0);
    chk("t5_n4_notick", 32'(tick[3]), 32'h0);
    step();
    chk("t5_n4_tick", 32'(tick[3]), 32'h1);
    chk("t5_ch3_done", 32'(cfg_ready), 32'h1);

    // 6: reset at cnt=3 of N=6 with an update pending
    cfg_div   = 16'd10;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t6_pending", 32'(cfg_ready), 32'h0);
    step();
    chk("t6_cnt2_clk", 32'(clk_out[3]), 32'h1);
    step();
    chk("t6_cnt3_clk", 32'(clk_out[3]), 32'h0);
    en       = 4'hF;
    and_mask = 4'hF;
    reset    = 1'b1;
    #1;
    chk("t6_rst_clk", 32'(clk_out), 32'h0);
    chk("t6_rst_tick", 32'(tick), 32'h0);
    chk("t6_rst_y", 32'(y), 32'h0);
    chk("t6_rst_rdy", 32'(cfg_ready), 32'h1);
    #2;
    reset = 1'b0;
    step();
    chk("t6_e1_clk", 32'(clk_out), 32'h0);
    step();
    chk("t6_e2_clk", 32'(clk_out), 32'hF);
    chk("t6_e2_tick", 32'(tick), 32'hF);
    chk("t6_e2_y", 32'(y), 32'h1);
    step();
    chk("t6_e3_clk", 32'(clk_out), 32'h0);
    chk("t6_e3_y", 32'(y), 32'h0);
    step();
    chk("t6_e4_tick3", 32'(tick[3]), 32'h1);

    // 6b: en low then high restarts phase like reset
    step();
    en = 4'h0;
    step();
    chk("t6_off_clk", 32'(clk_out), 32'h0);
    chk("t6_off_tick", 32'(tick), 32'h0);
    en = 4'hF;
    step();
    chk("t6_re1_clk", 32'(clk_out), 32'h0);
    chk("t6_re1_y", 32'(y), 32'h0);
    step();
    chk("t6_re2_clk", 32'(clk_out), 32'hF);
    chk("t6_re2_tick", 32'(tick), 32'hF);
    chk("t6_re2_y", 32'(y), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
